// File: rtl/execute_memory_reg.sv
// execute_memory_reg: Execute-to-Memory boundary of the pipelined CPU.
// Evaluates the E-stage condition code against the architectural NZCV flags,
// updates those flags from the ALU, qualifies the instruction's side effects
// by the condition result and latches everything into the M-stage register.
// Optional feature: define EXMEM_SQUASH_CNT_EN to add a 16-bit counter
// (SquashCount) of condition-failed instructions that carried side effects.
module execute_memory_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallM,
  input  logic             FlushM,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       ALUFlags,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [3:0]       WA3E,
  output logic             CondExE,
  output logic             PCRedirectE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             PCSrcM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M,
  output logic [3:0]       FlagsQ
`ifdef EXMEM_SQUASH_CNT_EN
  ,
  output logic [15:0]      SquashCount
`endif
);

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic             pc_src;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] write_data;
    logic [3:0]       wa3;
  } m_stage_t;

  m_stage_t   m_q, m_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       advance;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // The instruction moves into M (and may commit flags) only when neither held nor bubbled.
  assign advance = !StallM && !FlushM;

  // Condition check uses only the registered flags, so ALUFlags never reaches CondExE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cond_ex = 1'b0;
    case (CondE)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag next-state: each half of NZCV is written only by a passing, advancing instruction.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && advance) begin
      if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // M-register next-state: flush beats stall beats load; failed instructions keep their data.
  always_comb begin
    m_d = m_q;
    if (FlushM) begin
      m_d = '0;
    end else if (!StallM) begin
      m_d.reg_write  = RegWriteE && cond_ex;
      m_d.mem_write  = MemWriteE && cond_ex;
      m_d.mem_to_reg = MemtoRegE;
      m_d.pc_src     = PCSrcE && cond_ex;
      m_d.alu_result = ALUResultE;
      m_d.write_data = WriteDataE;
      m_d.wa3        = WA3E;
    end
  end

  // Pipeline state with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (reset) begin
      m_q     <= '0;
      flags_q <= '0;
    end else begin
      m_q     <= m_d;
      flags_q <= flags_d;
    end
  end

`ifdef EXMEM_SQUASH_CNT_EN
  logic [15:0] squash_cnt_q, squash_cnt_d;

  // Count advancing instructions whose side effects were cancelled; wraps naturally.
  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (advance && !cond_ex && (RegWriteE || MemWriteE || PCSrcE))
      squash_cnt_d = squash_cnt_q + 16'd1;
  end

  // Squash counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) squash_cnt_q <= '0;
    else       squash_cnt_q <= squash_cnt_d;
  end

  assign SquashCount = squash_cnt_q;
`endif

  assign CondExE     = cond_ex;
  assign PCRedirectE = PCSrcE && cond_ex;
  assign RegWriteM   = m_q.reg_write;
  assign MemWriteM   = m_q.mem_write;
  assign MemtoRegM   = m_q.mem_to_reg;
  assign PCSrcM      = m_q.pc_src;
  assign ALUResultM  = m_q.alu_result;
  assign WriteDataM  = m_q.write_data;
  assign WA3M        = m_q.wa3;
  assign FlagsQ      = flags_q;

endmodule

// File: tb/tb_execute_memory_reg.sv
// Scoreboard bench for execute_memory_reg: directed E-stage vectors push their
// hand-computed M-stage/flags expectations; a monitor pops one per clock edge.
module tb_execute_memory_reg;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [3:0] cond;
    logic [1:0] fw;
    logic [3:0] aluf;
    logic       rw;
    logic       mw;
    logic       mtr;
    logic       pcs;
    logic [7:0] alu;
    logic [7:0] wd;
    logic [3:0] wa3;
  } vec_t;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       mtr;
    logic       pcs;
    logic [7:0] alu;
    logic [7:0] wd;
    logic [3:0] wa3;
    logic [3:0] flags;
  } exp_t;

  logic       clk, reset;
  logic       StallM, FlushM;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  logic [3:0] ALUFlags;
  logic       RegWriteE, MemWriteE, MemtoRegE, PCSrcE;
  logic [7:0] ALUResultE, WriteDataE;
  logic [3:0] WA3E;
  logic       CondExE, PCRedirectE;
  logic       RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic [7:0] ALUResultM, WriteDataM;
  logic [3:0] WA3M, FlagsQ;
`ifdef EXMEM_SQUASH_CNT_EN
  logic [15:0] SquashCount;
`endif

  int   n_compared = 0;
  int   n_mismatched = 0;
  exp_t exp_q[$];

  execute_memory_reg #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .PCSrcE(PCSrcE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .WA3E(WA3E), .CondExE(CondExE), .PCRedirectE(PCRedirectE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .WA3M(WA3M), .FlagsQ(FlagsQ)
`ifdef EXMEM_SQUASH_CNT_EN
    , .SquashCount(SquashCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t observed();
    return '{RegWriteM, MemWriteM, MemtoRegM, PCSrcM, ALUResultM, WriteDataM, WA3M, FlagsQ};
  endfunction

  // Apply one vector on the falling edge, check the combinational outputs,
  // queue the expected registered state and advance to the next rising edge.
  task automatic drive(input vec_t v, input exp_t x, input logic exp_cond, input logic pulse_rst);
    @(negedge clk);
    {StallM, FlushM, CondE, FlagWriteE, ALUFlags} = {v.stall, v.flush, v.cond, v.fw, v.aluf};
    {RegWriteE, MemWriteE, MemtoRegE, PCSrcE} = {v.rw, v.mw, v.mtr, v.pcs};
    {ALUResultE, WriteDataE, WA3E} = {v.alu, v.wd, v.wa3};
    if (pulse_rst) begin
      reset = 1'b1;
      #1;
      check("async_reset_state", 64'(observed()), 64'(0));
      reset = 1'b0;
    end
    #1;
    check("cond_ex", 64'(CondExE), 64'(exp_cond));
    check("pc_redirect", 64'(PCRedirectE), 64'(v.pcs & exp_cond));
    exp_q.push_back(x);
    @(posedge clk);
  endtask

  // Monitor: just after every rising edge, compare against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check("m_stage", 64'(observed()), 64'(x));
      end
    end
  end

  initial begin
    reset = 1'b1;
    {StallM, FlushM, CondE, FlagWriteE, ALUFlags} = '0;
    {RegWriteE, MemWriteE, MemtoRegE, PCSrcE} = '0;
    {ALUResultE, WriteDataE, WA3E} = '0;
    #12;
    check("reset_state", 64'(observed()), 64'(0));
    reset = 1'b0;

    //          st fl cond     fw     aluf     rw mw mt pc alu    wd     wa3        rw mw mt pc alu    wd     wa3    flags    cond rst
    drive(vec_t'{0, 0, 4'hE, 2'b11, 4'b1010, 1, 0, 1, 0, 8'hA5, 8'h3C, 4'h5}, exp_t'{1, 0, 1, 0, 8'hA5, 8'h3C, 4'h5, 4'b1010}, 1, 0);
    // Reset pulsed mid-cycle; the next edge is an ordinary load.
    drive(vec_t'{0, 0, 4'hE, 2'b00, 4'b0000, 1, 0, 0, 0, 8'hA5, 8'h11, 4'h2}, exp_t'{1, 0, 0, 0, 8'hA5, 8'h11, 4'h2, 4'b0000}, 1, 1);
    // EQ with Z=0 fails: controls squashed, data still loads, flags untouched.
    drive(vec_t'{0, 0, 4'h0, 2'b11, 4'b1111, 1, 1, 1, 0, 8'h77, 8'h88, 4'h3}, exp_t'{0, 0, 1, 0, 8'h77, 8'h88, 4'h3, 4'b0000}, 0, 0);
    // AL writes N,Z only.
    drive(vec_t'{0, 0, 4'hE, 2'b10, 4'b0100, 0, 0, 0, 0, 8'h01, 8'h02, 4'h4}, exp_t'{0, 0, 0, 0, 8'h01, 8'h02, 4'h4, 4'b0100}, 1, 0);
    // EQ now passes on the flags written one cycle earlier.
    drive(vec_t'{0, 0, 4'h0, 2'b00, 4'b0000, 1, 1, 0, 1, 8'h10, 8'h20, 4'h6}, exp_t'{1, 1, 0, 1, 8'h10, 8'h20, 4'h6, 4'b0100}, 1, 0);
    // AL writes C,V only: 0100 -> 0111.
    drive(vec_t'{0, 0, 4'hE, 2'b01, 4'b1111, 0, 0, 0, 0, 8'h30, 8'h40, 4'h7}, exp_t'{0, 0, 0, 0, 8'h30, 8'h40, 4'h7, 4'b0111}, 1, 0);
    // N=0, V=1: GE fails, LT passes; Z=1,C=1: LS passes.
    drive(vec_t'{0, 0, 4'hA, 2'b11, 4'b0000, 1, 0, 0, 0, 8'h50, 8'h60, 4'h8}, exp_t'{0, 0, 0, 0, 8'h50, 8'h60, 4'h8, 4'b0111}, 0, 0);
    drive(vec_t'{0, 0, 4'hB, 2'b00, 4'b0000, 1, 0, 0, 0, 8'h51, 8'h61, 4'h9}, exp_t'{1, 0, 0, 0, 8'h51, 8'h61, 4'h9, 4'b0111}, 1, 0);
    drive(vec_t'{0, 0, 4'h9, 2'b00, 4'b0000, 0, 0, 0, 1, 8'h52, 8'h62, 4'hA}, exp_t'{0, 0, 0, 1, 8'h52, 8'h62, 4'hA, 4'b0111}, 1, 0);
    // Three stalled cycles with changing inputs: M and flags frozen.
    drive(vec_t'{1, 0, 4'hE, 2'b11, 4'b1000, 1, 1, 1, 0, 8'hC1, 8'hD1, 4'h1}, exp_t'{0, 0, 0, 1, 8'h52, 8'h62, 4'hA, 4'b0111}, 1, 0);
    drive(vec_t'{1, 0, 4'hE, 2'b11, 4'b1000, 1, 0, 1, 1, 8'hC2, 8'hD2, 4'h2}, exp_t'{0, 0, 0, 1, 8'h52, 8'h62, 4'hA, 4'b0111}, 1, 0);
    drive(vec_t'{1, 0, 4'hE, 2'b11, 4'b1000, 0, 1, 0, 0, 8'hC3, 8'hD3, 4'h3}, exp_t'{0, 0, 0, 1, 8'h52, 8'h62, 4'hA, 4'b0111}, 1, 0);
    // Stall together with flush: bubble, no flag write.
    drive(vec_t'{1, 1, 4'hE, 2'b11, 4'b1000, 1, 1, 1, 1, 8'hC4, 8'hD4, 4'h4}, exp_t'{0, 0, 0, 0, 8'h00, 8'h00, 4'h0, 4'b0111}, 1, 0);
    // Reserved condition never passes; AL redirects in the same cycle.
    drive(vec_t'{0, 0, 4'hF, 2'b00, 4'b0000, 0, 0, 0, 1, 8'h90, 8'h91, 4'hB}, exp_t'{0, 0, 0, 0, 8'h90, 8'h91, 4'hB, 4'b0111}, 0, 0);
    drive(vec_t'{0, 0, 4'hE, 2'b00, 4'b0000, 0, 0, 0, 1, 8'h92, 8'h93, 4'hC}, exp_t'{0, 0, 0, 1, 8'h92, 8'h93, 4'hC, 4'b0111}, 1, 0);
    // Flush alone: bubble, flags held; MI with N=0 fails, HI with Z=1 fails.
    drive(vec_t'{0, 1, 4'hE, 2'b11, 4'b1000, 1, 1, 1, 1, 8'hEE, 8'hEF, 4'hD}, exp_t'{0, 0, 0, 0, 8'h00, 8'h00, 4'h0, 4'b0111}, 1, 0);
    drive(vec_t'{0, 0, 4'h4, 2'b00, 4'b0000, 0, 1, 0, 0, 8'h33, 8'h44, 4'hE}, exp_t'{0, 0, 0, 0, 8'h33, 8'h44, 4'hE, 4'b0111}, 0, 0);
    drive(vec_t'{0, 0, 4'h8, 2'b00, 4'b0000, 0, 0, 1, 0, 8'h35, 8'h46, 4'hF}, exp_t'{0, 0, 1, 0, 8'h35, 8'h46, 4'hF, 4'b0111}, 0, 0);

`ifdef EXMEM_SQUASH_CNT_EN
    // Squashes so far: EQ fail, GE fail, reserved-cond fail, MI fail (mem write).
    #2;
    check("squash_count_init", 64'(SquashCount), 64'd4);
    for (int i = 0; i < 65530; i++)
      drive(vec_t'{0, 0, 4'hF, 2'b00, 4'b0000, 1, 0, 0, 0, 8'h00, 8'h00, 4'h0}, exp_t'{0, 0, 0, 0, 8'h00, 8'h00, 4'h0, 4'b0111}, 0, 0);
    #2;
    check("squash_count_fffe", 64'(SquashCount), 64'hFFFE);
    drive(vec_t'{0, 0, 4'hF, 2'b00, 4'b0000, 1, 0, 0, 0, 8'h00, 8'h00, 4'h0}, exp_t'{0, 0, 0, 0, 8'h00, 8'h00, 4'h0, 4'b0111}, 0, 0);
    #2;
    check("squash_count_ffff", 64'(SquashCount), 64'hFFFF);
    drive(vec_t'{0, 0, 4'hF, 2'b00, 4'b0000, 0, 0, 0, 1, 8'h00, 8'h00, 4'h0}, exp_t'{0, 0, 0, 0, 8'h00, 8'h00, 4'h0, 4'b0111}, 0, 0);
    #2;
    check("squash_count_wrap", 64'(SquashCount), 64'h0000);
    drive(vec_t'{1, 0, 4'hF, 2'b00, 4'b0000, 1, 1, 0, 0, 8'h12, 8'h34, 4'h5}, exp_t'{0, 0, 0, 0, 8'h00, 8'h00, 4'h0, 4'b0111}, 0, 0);
    #2;
    check("squash_count_stalled", 64'(SquashCount), 64'h0000);
`endif

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
